// File: rtl/div8by4_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// width and the controller state encodings.
package div8by4_seq_pkg;

   localparam int W_DEFAULT = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_ZERO = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

endpackage

// File: rtl/div8by4_seq_div_step.sv
// One restoring division step: compare the widened partial remainder with the
// divisor, subtract when it fits and emit the corresponding quotient bit.
module div_step #(
   parameter int W = 4
) (
   input  logic [W:0]   r_in,
   input  logic [W-1:0] den,
   output logic [W-1:0] r_out,
   output logic         qbit
);

   // Subtract-if-fits; when it does not fit r_in < den, so its top bit is zero.
   always_comb begin
      qbit  = (r_in >= {1'b0, den});
      r_out = qbit ? W'(r_in - {1'b0, den}) : r_in[W-1:0];
   end

endmodule

// File: rtl/div8by4_seq.sv
// Sequential restoring divider: {num_hi,num_lo} / den, one quotient bit per
// clock. The dividend register shifts left while quotient bits enter at the
// bottom, so after 2W steps it holds the quotient.
module div8by4_seq
   import div8by4_seq_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] num_lo,
   input  logic [W-1:0] num_hi,
   input  logic [W-1:0] den,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quot_lo,
   output logic [W-1:0] quot_hi,
   output logic [W-1:0] rem,
   output logic         div_zero
);

   localparam int              CW        = $clog2(2 * W);
   localparam logic [CW-1:0]   LAST_STEP = CW'(2 * W - 1);

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] dq_q, dq_d;
   logic [W-1:0]   r_q, r_d;
   logic [W-1:0]   den_q, den_d;
   logic [2*W-1:0] quot_q, quot_d;
   logic [W-1:0]   rem_q, rem_d;
   logic           dz_q, dz_d;
   logic [W-1:0]   step_r;
   logic           step_qbit;

   div_step #(.W(W)) u_step (
      .r_in  ({r_q, dq_q[2*W-1]}),
      .den   (den_q),
      .r_out (step_r),
      .qbit  (step_qbit)
   );

   // Next-state logic: accept in IDLE or FIN, iterate in RUN, short-cut in ZERO.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dq_d    = dq_q;
      r_d     = r_q;
      den_d   = den_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE, S_FIN: begin
            // FIN has busy low, so a start in the done cycle is taken here.
            state_d = S_IDLE;
            if (start) begin
               dq_d    = {num_hi, num_lo};
               den_d   = den;
               r_d     = '0;
               cnt_d   = '0;
               state_d = (den != '0) ? S_RUN : S_ZERO;
            end
         end
         S_RUN: begin
            dq_d  = {dq_q[2*W-2:0], step_qbit};
            r_d   = step_r;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               state_d = S_FIN;
               quot_d  = {dq_q[2*W-2:0], step_qbit};
               rem_d   = step_r;
               dz_d    = 1'b0;
            end
         end
         default: begin
            // Divide by zero: all-ones quotient, low dividend half as remainder.
            state_d = S_FIN;
            quot_d  = '1;
            rem_d   = dq_q[W-1:0];
            dz_d    = 1'b1;
         end
      endcase
   end

   // Control and result registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
      end
   end

   // Working datapath registers; only meaningful while busy, so no reset.
   always_ff @(posedge clk) begin
      dq_q  <= dq_d;
      r_q   <= r_d;
      den_q <= den_d;
   end

   assign busy     = (state_q == S_RUN) || (state_q == S_ZERO);
   assign done     = (state_q == S_FIN);
   assign quot_hi  = quot_q[2*W-1:W];
   assign quot_lo  = quot_q[W-1:0];
   assign rem      = rem_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_div8by4_seq.sv
// Bench for div8by4_seq: a driver issues requests and queues the expected
// results; an independent monitor pops and compares on every done pulse.
module tb_div8by4_seq;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] num_lo = '0;
   logic [W-1:0] num_hi = '0;
   logic [W-1:0] den = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quot_lo;
   logic [W-1:0] quot_hi;
   logic [W-1:0] rem;
   logic         div_zero;

   div8by4_seq #(.W(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .num_lo   (num_lo),
      .num_hi   (num_hi),
      .den      (den),
      .busy     (busy),
      .done     (done),
      .quot_lo  (quot_lo),
      .quot_hi  (quot_hi),
      .rem      (rem),
      .div_zero (div_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
      int         due;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   logic [7:0] hold_q = '0;
   logic [3:0] hold_r = '0;
   logic       hold_z = 1'b0;
   bit         rt_mode = 1'b0;
   int         prev_done = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division, with the divide-by-zero rule.
   function automatic exp_t model(input logic [7:0] n, input logic [3:0] d);
      exp_t m;
      if (d == 4'd0) begin
         m.q = 8'hFF;
         m.r = n[3:0];
         m.z = 1'b1;
      end else begin
         m.q = 8'(int'(n) / int'(d));
         m.r = 4'(int'(n) % int'(d));
         m.z = 1'b0;
      end
      m.due = 0;
      return m;
   endfunction

   // Monitor: score every done pulse, and check outputs hold while busy.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (done) begin
            chk("done_busy_excl", int'(busy), 0);
            if (sbq.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("quot", int'({quot_hi, quot_lo}), int'(e.q));
               chk("rem", int'(rem), int'(e.r));
               chk("div_zero", int'(div_zero), int'(e.z));
               chk("latency", cyc, e.due);
               hold_q = e.q;
               hold_r = e.r;
               hold_z = e.z;
               if (rt_mode && prev_done >= 0) chk("rt_spacing", cyc - prev_done, 9);
               prev_done = cyc;
            end
         end else if (busy) begin
            chk("hold_while_busy", int'({quot_hi, quot_lo, rem, div_zero}),
                int'({hold_q, hold_r, hold_z}));
         end
      end
   end

   // Issue one request once busy is low; called and returns at a negedge.
   task automatic issue(input logic [7:0] n, input logic [3:0] d, input bit push);
      int   guard = 0;
      exp_t e;
      while (busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (busy) chk("issue_timeout", 1, 0);
      start  = 1'b1;
      num_hi = n[7:4];
      num_lo = n[3:0];
      den    = d;
      if (push) begin
         e = model(n, d);
         e.due = cyc + 1 + ((d == 4'd0) ? 1 : 2 * W);
         sbq.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive a start regardless of busy; used only while an operation runs.
   task automatic poke(input logic [7:0] n, input logic [3:0] d);
      start  = 1'b1;
      num_hi = n[7:4];
      num_lo = n[3:0];
      den    = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (sbq.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (sbq.size() != 0) begin
         chk("drain_timeout", sbq.size(), 0);
         sbq.delete();
      end
      @(negedge clk);
   endtask

   logic [7:0] dir_n [7] = '{8'h15, 8'hE1, 8'hFF, 8'h10, 8'h64, 8'h5A, 8'h09};
   logic [3:0] dir_d [7] = '{4'd3, 4'd15, 4'd1, 4'd8, 4'd7, 4'd0, 4'd3};

   initial begin
      logic [7:0] rn;
      logic [3:0] rd;

      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({busy, done, div_zero, quot_hi, quot_lo, rem}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases, including full-width quotient and divide by zero.
      for (int i = 0; i < 7; i++) issue(dir_n[i], dir_d[i], 1'b1);
      wait_drain();

      // A start while busy must be ignored.
      issue(8'h15, 4'd3, 1'b1);
      @(negedge clk);
      poke(8'hFF, 4'd1);
      wait_drain();
      repeat (12) @(negedge clk);

      // Reset in the middle of an operation discards it.
      issue(8'hFF, 4'd1, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop_reset_outputs", int'({busy, done, div_zero, quot_hi, quot_lo, rem}), 0);
      hold_q = '0;
      hold_r = '0;
      hold_z = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("idle_after_reset", int'({busy, done}), 0);

      // Round trip with mult4 products, back to back.
      rt_mode   = 1'b1;
      prev_done = -1;
      for (int a = 0; a < 16; a++) issue(8'(a * 5), 4'd5, 1'b1);
      wait_drain();
      rt_mode = 1'b0;

      // Randomized requests with gaps, zero divisors and ignored starts.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         rn = 8'($urandom);
         rd = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         issue(rn, rd, 1'b1);
         if ($urandom_range(0, 3) == 0) poke(8'($urandom), 4'($urandom));
      end
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
